line_fetch_arbiter: RTL and testbench

//  Sequences per-line pixel fetches from the shared frame RAM into a two-bank line buffer for the
//  VGA display path. It also arbitrates that RAM between the display fetch and game-logic writes.

---
 rtl/line_fetch_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_line_fetch_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/line_fetch_arbiter.sv
// line_fetch_arbiter
//   Fetches one display line at a time from the shared frame RAM into a
//   two-bank line buffer. While the display reads one bank, the next line is
//   fetched into the other bank. The module also shares the frame RAM port
//   between these reads and game-logic writes.
//
// Ports
//   clk_i, rst_ni        pixel clock, asynchronous active-low reset
//   new_line_i           1-cycle pulse at the end of each display line
//   frame_start_i        1-cycle pulse at the start of vertical blanking
//   wr_req_i/addr/data   game-logic write request (held until granted)
//   wr_grant_o           write issued to the RAM this cycle
//   mem_en_o/we/addr/wdata, mem_rdata_i
//                        frame RAM port (read data arrives one cycle later)
//   lb_we_o/bank/waddr/wdata
//                        line-buffer write port
//   disp_bank_o          bank the display reads from
//   underrun_o           sticky: a line was not ready at its new_line
//   clr_underrun_i       synchronous clear of underrun_o
module line_fetch_arbiter #(
  parameter int WORD_W     = 48,
  parameter int LINE_WORDS = 106,
  parameter int LINES      = 480,
  parameter int ADDR_W     = 16,
  parameter int WR_SLOT    = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              new_line_i,
  input  logic              frame_start_i,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WORD_W-1:0] wr_data_i,
  output logic              wr_grant_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  input  logic [WORD_W-1:0] mem_rdata_i,
  output logic              lb_we_o,
  output logic              lb_bank_o,
  output logic [6:0]        lb_waddr_o,
  output logic [WORD_W-1:0] lb_wdata_o,
  output logic              disp_bank_o,
  output logic              underrun_o,
  input  logic              clr_underrun_i
);

  localparam int IDX_W  = 7;
  localparam int LP_W   = $clog2(LINES + 1);
  localparam int SLOT_W = (WR_SLOT > 1) ? $clog2(WR_SLOT) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(LINE_WORDS - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(WR_SLOT - 1);
  localparam logic [LP_W-1:0]   LINES_C   = LP_W'(LINES);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(LINE_WORDS);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, READY} state_t;

  state_t            state_q, state_d;
  logic [LP_W-1:0]   line_ptr_q, line_ptr_d;
  // base_q is the RAM address of word 0 of the line currently being fetched
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              disp_bank_q, disp_bank_d;
  logic              underrun_q, underrun_d;
  // capture pipeline: describes the read issued in the previous cycle
  logic              cap_valid_q, cap_valid_d;
  logic [IDX_W-1:0]  cap_idx_q, cap_idx_d;
  logic              cap_bank_q, cap_bank_d;

  logic wr_fire, rd_fire, busy, underrun_evt, lb_fire;

  always_comb begin
    busy         = (state_q == FETCH) || (state_q == DRAIN);
    // Outside FETCH the RAM is free; inside FETCH only the last slot is offered.
    wr_fire      = wr_req_i && ((state_q != FETCH) || (slot_q == SLOT_LAST));
    // No read is launched in a cycle that aborts the fetch.
    rd_fire      = (state_q == FETCH) && !wr_fire && !frame_start_i && !new_line_i;
    underrun_evt = busy && new_line_i && !frame_start_i;
    // Data returning in an abort cycle belongs to the abandoned line.
    lb_fire      = cap_valid_q && !frame_start_i && !new_line_i;
  end

  always_comb begin
    wr_grant_o  = wr_fire;
    mem_en_o    = wr_fire || rd_fire;
    mem_we_o    = wr_fire;
    mem_addr_o  = '0;
    if (wr_fire) begin
      mem_addr_o = wr_addr_i;
    end else if (rd_fire) begin
      mem_addr_o = base_q + {{(ADDR_W-IDX_W){1'b0}}, rd_idx_q};
    end
    mem_wdata_o = wr_fire ? wr_data_i : '0;
    lb_we_o     = lb_fire;
    lb_bank_o   = cap_bank_q;
    lb_waddr_o  = cap_idx_q;
    lb_wdata_o  = lb_fire ? mem_rdata_i : '0;
    disp_bank_o = disp_bank_q;
    underrun_o  = underrun_q;
  end

  always_comb begin
    state_d     = state_q;
    line_ptr_d  = line_ptr_q;
    base_d      = base_q;
    rd_idx_d    = rd_idx_q;
    slot_d      = slot_q;
    disp_bank_d = disp_bank_q;
    underrun_d  = underrun_q;
    cap_valid_d = rd_fire;
    cap_idx_d   = rd_idx_q;
    cap_bank_d  = ~disp_bank_q;

    if (state_q == FETCH) begin
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
    end

    case (state_q)
      FETCH: begin
        if (rd_fire) begin
          if (rd_idx_q == IDX_LAST) begin
            rd_idx_d = '0;
            state_d  = DRAIN;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (lb_fire) state_d = READY;
      end
      default: ;
    endcase

    // Clear first so that a coincident underrun event keeps the flag set.
    if (clr_underrun_i) underrun_d = 1'b0;
    if (underrun_evt)   underrun_d = 1'b1;

    if (frame_start_i) begin
      line_ptr_d = '0;
      base_d     = '0;
      rd_idx_d   = '0;
      slot_d     = '0;
      state_d    = FETCH;
    end else if (new_line_i && (state_q != IDLE)) begin
      // Only a completed line is shown; on underrun the old bank repeats and
      // the next line is fetched into the same idle bank.
      if (state_q == READY) disp_bank_d = ~disp_bank_q;
      line_ptr_d = line_ptr_q + 1'b1;
      base_d     = base_q + LINE_STEP;
      rd_idx_d   = '0;
      slot_d     = '0;
      state_d    = ((line_ptr_q + 1'b1) < LINES_C) ? FETCH : IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      line_ptr_q  <= '0;
      base_q      <= '0;
      rd_idx_q    <= '0;
      slot_q      <= '0;
      disp_bank_q <= 1'b0;
      underrun_q  <= 1'b0;
      cap_valid_q <= 1'b0;
      cap_idx_q   <= '0;
      cap_bank_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_ptr_q  <= line_ptr_d;
      base_q      <= base_d;
      rd_idx_q    <= rd_idx_d;
      slot_q      <= slot_d;
      disp_bank_q <= disp_bank_d;
      underrun_q  <= underrun_d;
      cap_valid_q <= cap_valid_d;
      cap_idx_q   <= cap_idx_d;
      cap_bank_q  <= cap_bank_d;
    end
  end

endmodule

// File: tb/tb_line_fetch_arbiter.sv
// Directed bench for line_fetch_arbiter: frame RAM model returns a pattern
// derived from the read address one cycle after each read strobe.
module tb_line_fetch_arbiter;

  localparam int LW = 106;
  localparam int WR_SLOT = 4;
  localparam logic [15:0] WA = 16'hBEEF;
  localparam logic [47:0] WD = 48'h1234_5678_9ABC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        new_line = 1'b0, frame_start = 1'b0, wr_req = 1'b0, clr_underrun = 1'b0;
  logic [15:0] wr_addr = WA;
  logic [47:0] wr_data = WD;
  logic        wr_grant, mem_en, mem_we, lb_we, lb_bank, disp_bank, underrun;
  logic [15:0] mem_addr;
  logic [47:0] mem_wdata, lb_wdata;
  logic [47:0] mem_rdata = '0;
  logic [6:0]  lb_waddr;

  int tests = 0;
  int fails = 0;
  int r_reads, r_bad_rd, r_lbw, r_bad_lb, r_last, r_grants, r_bad_wr, r_act;

  always #5 clk = ~clk;

  line_fetch_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n), .new_line_i(new_line), .frame_start_i(frame_start),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_grant_o(wr_grant),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .lb_we_o(lb_we), .lb_bank_o(lb_bank), .lb_waddr_o(lb_waddr),
    .lb_wdata_o(lb_wdata), .disp_bank_o(disp_bank), .underrun_o(underrun),
    .clr_underrun_i(clr_underrun)
  );

  function automatic logic [47:0] data_of(input logic [15:0] a);
    return {a, a ^ 16'hFFFF, a ^ 16'h5A5A};
  endfunction

  always_ff @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= data_of(mem_addr);
  end

  logic [125:0] all_outs;
  assign all_outs = {wr_grant, mem_en, mem_we, mem_addr, mem_wdata, lb_we, lb_bank,
                     lb_waddr, lb_wdata, disp_bank, underrun};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive pulses at the falling edge, observe 1 ns later.
  task automatic next_cycle(input bit nl, input bit fs, input bit clr);
    @(negedge clk);
    new_line = nl; frame_start = fs; clr_underrun = clr; wr_req = 1'b0;
    #1;
  endtask

  // Follow a fetch for up to 'budget' cycles, checking every read, write and
  // line-buffer write against the expected line base and bank.
  task automatic watch(input int base, input logic bank, input int budget, input bit hold_wr);
    int prev_g;
    r_reads = 0; r_bad_rd = 0; r_lbw = 0; r_bad_lb = 0; r_last = -1;
    r_grants = 0; r_bad_wr = 0; prev_g = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      new_line = 1'b0; frame_start = 1'b0; clr_underrun = 1'b0;
      wr_req = hold_wr && (r_reads < LW);
      #1;
      if (mem_en && !mem_we) begin
        if (mem_addr !== 16'(base + r_reads)) r_bad_rd++;
        r_reads++;
      end
      if (mem_en && mem_we) begin
        r_grants++;
        if (!wr_grant || mem_addr !== WA || mem_wdata !== WD) r_bad_wr++;
        if (c - prev_g != WR_SLOT) r_bad_wr++;
        prev_g = c;
      end
      if (wr_grant && !(mem_en && mem_we)) r_bad_wr++;
      if (lb_we) begin
        if (lb_bank !== bank || lb_waddr !== 7'(r_lbw) ||
            lb_wdata !== data_of(16'(base + r_lbw))) r_bad_lb++;
        r_lbw++;
        if (r_lbw == LW) r_last = c;
      end
      if (r_last > 0 && c >= r_last + 2) break;
    end
  endtask

  task automatic quiet(input int n);
    r_act = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      new_line = 1'b0; frame_start = 1'b0; clr_underrun = 1'b0; wr_req = 1'b0;
      #1;
      if (mem_en || lb_we || wr_grant) r_act++;
    end
  endtask

  task automatic chk_full(input string tag, input int last_exp);
    chk({tag, "_reads"}, 128'(r_reads), 128'(LW));
    chk({tag, "_rdaddr"}, 128'(r_bad_rd), 128'(0));
    chk({tag, "_lbw"}, 128'(r_lbw), 128'(LW));
    chk({tag, "_lbdata"}, 128'(r_bad_lb), 128'(0));
    chk({tag, "_last"}, 128'(r_last), 128'(last_exp));
  endtask

  initial begin
    int err;
    // Reset state
    #3;
    chk("reset_outs", 128'(all_outs), 128'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    quiet(3);
    chk("idle_after_reset", 128'(r_act), 128'(0));

    // 1: frame_start -> line 0 at 0..105 into bank 1, last lb_we at cycle 107
    next_cycle(0, 1, 0);
    chk("fs_cycle_no_access", 128'(mem_en), 128'(0));
    watch(0, 1'b1, 200, 1'b0);
    chk_full("line0", 107);
    chk("line0_grants", 128'(r_grants), 128'(0));

    // 2: new_line -> display bank 1, line 1 at 106..211 into bank 0
    next_cycle(1, 0, 0);
    watch(106, 1'b0, 200, 1'b0);
    chk_full("line1", 107);
    chk("line1_disp", 128'(disp_bank), 128'(1));
    err = 0;
    for (int l = 2; l < 480; l++) begin
      next_cycle(1, 0, 0);
      watch(l * LW, ~l[0], 200, 1'b0);
      err += int'(r_reads != LW) + r_bad_rd + int'(r_lbw != LW) + r_bad_lb + int'(r_last != 107);
      err += int'(disp_bank !== l[0]);
    end
    chk("lines2_479", 128'(err), 128'(0));
    next_cycle(1, 0, 0);
    quiet(200);
    chk("after_479_idle", 128'(r_act), 128'(0));
    chk("after_479_disp", 128'(disp_bank), 128'(0));
    next_cycle(1, 0, 0);
    quiet(20);
    chk("newline_idle_ignored", 128'(r_act), 128'(0));
    chk("newline_idle_disp", 128'(disp_bank), 128'(0));

    // 3: write held throughout a fetch
    next_cycle(0, 1, 0);
    watch(0, 1'b1, 300, 1'b1);
    chk_full("wrfetch", 142);
    chk("wrfetch_grants", 128'(r_grants), 128'(35));
    chk("wrfetch_wrbad", 128'(r_bad_wr), 128'(0));

    // 4: underrun at cycle 50 of the fetch of line 1
    next_cycle(1, 0, 0);
    watch(106, 1'b0, 49, 1'b0);
    chk("ur_partial_reads", 128'(r_reads), 128'(49));
    chk("ur_partial_lbw", 128'(r_lbw), 128'(48));
    next_cycle(1, 0, 0);
    chk("ur_cycle_no_lbwe", 128'(lb_we), 128'(0));
    chk("ur_cycle_no_read", 128'(mem_en), 128'(0));
    watch(212, 1'b0, 200, 1'b0);
    chk_full("ur_refetch", 107);
    chk("ur_flag", 128'(underrun), 128'(1));
    chk("ur_disp", 128'(disp_bank), 128'(1));
    next_cycle(0, 0, 1);
    next_cycle(0, 0, 0);
    chk("ur_cleared", 128'(underrun), 128'(0));

    // 5: frame_start and new_line together mid-fetch
    next_cycle(1, 0, 0);
    watch(318, 1'b1, 20, 1'b0);
    chk("fsnl_partial_reads", 128'(r_reads), 128'(20));
    next_cycle(1, 1, 0);
    chk("fsnl_no_lbwe", 128'(lb_we), 128'(0));
    watch(0, 1'b1, 200, 1'b0);
    chk_full("fsnl_refetch", 107);
    chk("fsnl_disp", 128'(disp_bank), 128'(0));
    chk("fsnl_underrun", 128'(underrun), 128'(0));
    // clear coincident with an underrun event: flag stays set
    next_cycle(1, 0, 0);
    watch(106, 1'b0, 10, 1'b0);
    next_cycle(1, 0, 1);
    next_cycle(0, 0, 0);
    chk("clr_vs_underrun", 128'(underrun), 128'(1));

    // 6: asynchronous reset during a fetch
    next_cycle(0, 0, 0);
    chk("pre_reset_busy", 128'(lb_we), 128'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", 128'(all_outs), 128'(0));
    next_cycle(0, 0, 0);
    chk("held_reset_outs", 128'(all_outs), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    quiet(20);
    chk("post_reset_quiet", 128'(r_act), 128'(0));
    next_cycle(0, 1, 0);
    watch(0, 1'b1, 200, 1'b0);
    chk_full("post_reset_line0", 107);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
